gcd_scheduler: RTL and testbench

- Shares one GCD datapath (control + datapath pair) between two requesters.
- Arbitrates round-robin, latches operands, pulses the core start, waits for core done, returns the result with a valid/ready response handshake.
- Bypasses the core for zero operands, which would never terminate in the subtractive core.
- Sits between the host-side requesters and the GCD core top.

---
 rtl/gcd_pkg.sv | 18 +
 rtl/gcd_scheduler_if.sv | 43 ++++
 rtl/gcd_rr_arbiter.sv | 29 ++
 rtl/gcd_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_gcd_scheduler.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and constants for the GCD scheduler slice.
package gcd_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Requester indices, also the encoding of rsp_id and last_grant.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

endpackage

// File: rtl/gcd_scheduler_if.sv
// gcd_scheduler_if: requester, core and response signals of the scheduler.
// slave is the scheduler's view; master is the surrounding system's view.
interface gcd_scheduler_if
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_y;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_y;
  logic             req1_ready;
  logic             core_start;
  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_y;
  logic             core_done;
  logic [WIDTH-1:0] core_gcd;
  logic             core_abort;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_gcd;
  logic             rsp_err;
  logic             rsp_ready;
  logic             busy;

  modport slave (
    input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
           core_done, core_gcd, rsp_ready,
    output req0_ready, req1_ready, core_start, core_x, core_y, core_abort,
           rsp_valid, rsp_id, rsp_gcd, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
           core_done, core_gcd, rsp_ready,
    input  req0_ready, req1_ready, core_start, core_x, core_y, core_abort,
           rsp_valid, rsp_id, rsp_gcd, rsp_err, busy
  );

endinterface

// File: rtl/gcd_rr_arbiter.sv
// gcd_rr_arbiter: combinational 2-way round-robin grant. On a tie the
// requester that did not win last time is granted.
module gcd_rr_arbiter
  import gcd_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  input  logic i_enable,
  output logic o_gnt0,
  output logic o_gnt1
);

  // Grant selection; nothing is granted while disabled.
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_enable) begin
      if (i_valid0 && i_valid1) begin
        o_gnt0 = (i_last_grant == REQ1);
        o_gnt1 = (i_last_grant == REQ0);
      end else begin
        o_gnt0 = i_valid0;
        o_gnt1 = i_valid1;
      end
    end
  end

endmodule

// File: rtl/gcd_scheduler.sv
// gcd_scheduler: shares one GCD core between two requesters. Round-robin
// accept, operand latch, one-cycle core start, wait for done, then a
// valid/ready response. Zero operands bypass the core (gcd = x|y).
// Optional feature macro: GCD_SCHED_TIMEOUT_EN -- abort the core and return
// an error response after TIMEOUT_CYCLES WAIT cycles without core_done.
module gcd_scheduler
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH          = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 512,
  parameter int unsigned CNT_W          = 10
) (
  input  logic           clk,
  input  logic           reset,
  gcd_scheduler_if.slave bus
);

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
    $error("gcd_scheduler: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_gcd;

  logic             w_idle;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_xfer0;
  logic             w_xfer1;
  logic             w_xfer;
  logic             w_xfer_id;
  logic [WIDTH-1:0] w_sel_x;
  logic [WIDTH-1:0] w_sel_y;
  logic             w_zero;
  logic             w_core_start;
  logic             w_rsp_valid;
  logic             w_busy;
  logic             w_done_ok;
  logic             w_timeout;

  assign w_idle = (r_state == IDLE);

  gcd_rr_arbiter u_arb (
    .i_valid0     (bus.req0_valid),
    .i_valid1     (bus.req1_valid),
    .i_last_grant (r_last_grant),
    .i_enable     (w_idle),
    .o_gnt0       (w_gnt0),
    .o_gnt1       (w_gnt1)
  );

  assign w_xfer0   = bus.req0_valid & w_gnt0;
  assign w_xfer1   = bus.req1_valid & w_gnt1;
  assign w_xfer    = w_xfer0 | w_xfer1;
  assign w_xfer_id = w_xfer1 ? REQ1 : REQ0;
  assign w_sel_x   = w_xfer1 ? bus.req1_x : bus.req0_x;
  assign w_sel_y   = w_xfer1 ? bus.req1_y : bus.req0_y;
  assign w_zero    = (w_sel_x == '0) || (w_sel_y == '0);
  assign w_done_ok = (r_state == WAIT) && bus.core_done;

`ifdef GCD_SCHED_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // core_done on the timeout cycle takes priority, so no abort then.
  assign w_timeout = (r_state == WAIT) && !bus.core_done &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT cycle counter, cleared while launching.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == LAUNCH) begin
      r_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Error flag of the pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_xfer || w_done_ok) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign bus.core_abort = w_timeout;
  assign bus.rsp_err    = r_err;
`else
  assign w_timeout      = 1'b0;
  assign bus.core_abort = 1'b0;
  assign bus.rsp_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next       = r_state;
    w_core_start = 1'b0;
    w_rsp_valid  = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_xfer) begin
          w_next = w_zero ? RESPOND : LAUNCH;
        end
      end
      LAUNCH: begin
        w_core_start = 1'b1;
        w_next       = WAIT;
      end
      WAIT: begin
        if (bus.core_done || w_timeout) begin
          w_next = RESPOND;
        end
      end
      RESPOND: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand, id and round-robin history latched on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_id         <= REQ0;
      r_last_grant <= REQ1;
    end else if (w_xfer) begin
      r_x          <= w_sel_x;
      r_y          <= w_sel_y;
      r_id         <= w_xfer_id;
      r_last_grant <= w_xfer_id;
    end
  end

  // Result register: bypass value on accept, core result on done, 0 on abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gcd <= '0;
    end else if (w_xfer && w_zero) begin
      r_gcd <= w_sel_x | w_sel_y;
    end else if (w_done_ok) begin
      r_gcd <= bus.core_gcd;
    end else if (w_timeout) begin
      r_gcd <= '0;
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.core_start = w_core_start;
  assign bus.core_x     = r_x;
  assign bus.core_y     = r_y;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_gcd    = r_gcd;
  assign bus.busy       = w_busy;

endmodule

// File: tb/tb_gcd_scheduler.sv
// tb_gcd_scheduler: randomized and directed checks of gcd_scheduler against a
// transaction-level reference (Euclid gcd, round-robin rule, latency rules).
module tb_gcd_scheduler;
  localparam int unsigned W  = 8;
  localparam int unsigned TO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  gcd_scheduler_if #(.WIDTH(W)) bus ();

  gcd_scheduler #(.WIDTH(W), .TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned p, q, t;
    p = a;
    q = b;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return W'(p);
  endfunction

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return '0;
    return W'($urandom_range(1, 255));
  endfunction

  // Core stand-in: returns the true gcd after cm_lat WAIT cycles (random if 0).
  int unsigned cm_lat    = 0;
  int unsigned cm_starts = 0;
  logic [W-1:0] cm_sx, cm_sy;
  bit stale_req = 1'b0;

  initial begin : core_model
    bit st;
    bit cbusy;
    int unsigned cnt, hold;
    logic [W-1:0] sx, sy, res;
    cbusy = 1'b0;
    cnt = 0;
    hold = 0;
    res = '0;
    bus.core_done = 1'b0;
    bus.core_gcd  = '0;
    forever begin
      @(negedge clk);
      st = bus.core_start;
      sx = bus.core_x;
      sy = bus.core_y;
      @(posedge clk);
      #1;
      bus.core_done = 1'b0;
      bus.core_gcd  = W'($urandom);
      if (reset) begin
        cbusy = 1'b0;
      end else if (st) begin
        cbusy = 1'b1;
        cm_starts++;
        cm_sx = sx;
        cm_sy = sy;
        cnt   = (cm_lat != 0) ? cm_lat : $urandom_range(1, 12);
        hold  = $urandom_range(1, 2);
        res   = ref_gcd(sx, sy);
      end
      if (cbusy) begin
        if (cnt > 1) cnt--;
        else begin
          bus.core_done = 1'b1;
          bus.core_gcd  = res;
          hold--;
          if (hold == 0) cbusy = 1'b0;
        end
      end
      if (stale_req) begin
        bus.core_done = 1'b1;
        bus.core_gcd  = 8'hA5;
        stale_req     = 1'b0;
      end
    end
  end

  // Reference model and per-cycle compare.
  bit m_idle = 1'b1, m_launch = 1'b0, m_wait = 1'b0, m_rsp = 1'b0;
  bit m_last = 1'b1, m_id = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_x = '0, m_y = '0, m_gcd = '0;
  int unsigned m_wcnt = 0;
  int unsigned n_abort = 0;
  bit e0, e1, timeout_now;
  int gr_log[$];
  int rsp_log[$];

  always @(negedge clk) begin
    if (reset) begin
      m_idle = 1'b1; m_launch = 1'b0; m_wait = 1'b0; m_rsp = 1'b0; m_last = 1'b1;
    end else begin
      e0 = 1'b0;
      e1 = 1'b0;
      if (m_idle) begin
        if (bus.req0_valid && bus.req1_valid) begin
          e0 = m_last;
          e1 = !m_last;
        end else begin
          e0 = bus.req0_valid;
          e1 = bus.req1_valid;
        end
      end
      timeout_now = 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
      timeout_now = m_wait && !bus.core_done && (m_wcnt == TO);
`endif
      if (bus.core_abort === 1'b1) n_abort++;
      chk("req0_ready", bus.req0_ready, e0);
      chk("req1_ready", bus.req1_ready, e1);
      chk("busy", bus.busy, !m_idle);
      chk("core_start", bus.core_start, m_launch);
      chk("core_abort", bus.core_abort, timeout_now);
      chk("rsp_valid", bus.rsp_valid, m_rsp);
      if (m_launch || m_wait) begin
        chk("core_x", bus.core_x, m_x);
        chk("core_y", bus.core_y, m_y);
      end
      if (m_rsp) begin
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_gcd", bus.rsp_gcd, m_gcd);
        chk("rsp_err", bus.rsp_err, m_err);
      end
      if (e0 || e1) begin
        m_id   = e1;
        m_x    = e1 ? bus.req1_x : bus.req0_x;
        m_y    = e1 ? bus.req1_y : bus.req0_y;
        m_last = m_id;
        gr_log.push_back(int'(m_id));
        m_idle = 1'b0;
        m_gcd  = ref_gcd(m_x, m_y);
        m_err  = 1'b0;
        if (m_x == '0 || m_y == '0) m_rsp = 1'b1;
        else m_launch = 1'b1;
      end else if (m_launch) begin
        m_launch = 1'b0;
        m_wait   = 1'b1;
        m_wcnt   = 1;
      end else if (m_wait) begin
        if (bus.core_done) begin
          m_wait = 1'b0;
          m_rsp  = 1'b1;
        end else if (timeout_now) begin
          m_wait = 1'b0;
          m_rsp  = 1'b1;
          m_gcd  = '0;
          m_err  = 1'b1;
        end else begin
          m_wcnt++;
        end
      end else if (m_rsp && bus.rsp_ready) begin
        m_rsp  = 1'b0;
        m_idle = 1'b1;
        rsp_log.push_back(int'(m_gcd));
      end
    end
  end

  task automatic send(input bit id, input logic [W-1:0] x, input logic [W-1:0] y);
    bit got;
    got = 1'b0;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_x = x; bus.req1_y = y; end
    else begin bus.req0_valid = 1'b1; bus.req0_x = x; bus.req0_y = y; end
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("send_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (id) bus.req1_valid = 1'b0;
    else bus.req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input bit id, input logic [W-1:0] g, input bit err);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({name, "_rsp_timeout"}, 32'd0, 32'd1);
    else begin
      chk({name, "_id"}, bus.rsp_id, id);
      chk({name, "_gcd"}, bus.rsp_gcd, g);
      chk({name, "_err"}, bus.rsp_err, err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit a0, a1;
    int unsigned s0, ab0, grants, guard;
    bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
    bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_core_x", bus.core_x, 0);
    chk("rst_core_y", bus.core_y, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_gcd", bus.rsp_gcd, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_core_abort", bus.core_abort, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single request through the core.
    cm_lat = 10;
    s0 = cm_starts;
    send(1'b0, 8'd48, 8'd18);
    wait_rsp("single", 1'b0, 8'd6, 1'b0);
    chk("single_starts", cm_starts - s0, 1);
    chk("single_core_x", cm_sx, 48);
    chk("single_core_y", cm_sy, 18);

    // Reset in the middle of WAIT.
    cm_lat = 50;
    send(1'b1, 8'd9, 8'd6);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_core_x", bus.core_x, 0);
    chk("midrst_core_y", bus.core_y, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_core_start", bus.core_start, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cm_lat = 0;
    stale_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("stale_done_ignored", bus.busy, 0);

    // Both requesters continuously valid: strict alternation from req0.
    gr_log.delete();
    rsp_log.delete();
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b1; bus.req0_x = 8'd12; bus.req0_y = 8'd8;
    bus.req1_valid = 1'b1; bus.req1_x = 8'd35; bus.req1_y = 8'd14;
    grants = 0;
    guard  = 0;
    while (grants < 16 && guard < 2000) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      guard++;
      @(posedge clk);
      #1;
      if (a0) begin grants++; bus.req0_x = W'($urandom_range(1, 255)); bus.req0_y = W'($urandom_range(1, 255)); end
      if (a1) begin grants++; bus.req1_x = W'($urandom_range(1, 255)); bus.req1_y = W'($urandom_range(1, 255)); end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (guard >= 2000) chk("alt_timeout", 32'd0, 32'd1);
    wait_idle("alt");
    chk("alt_count", gr_log.size(), 16);
    for (int i = 0; i < 16 && i < gr_log.size(); i++) chk("alt_order", gr_log[i], i % 2);
    if (rsp_log.size() >= 2) begin
      chk("alt_first_gcd", rsp_log[0], 4);
      chk("alt_second_gcd", rsp_log[1], 7);
    end else chk("alt_rsp_count", rsp_log.size(), 2);

    // Zero-operand bypass.
    s0 = cm_starts;
    send(1'b1, 8'd0, 8'd25);
    wait_rsp("bypass25", 1'b1, 8'd25, 1'b0);
    send(1'b0, 8'd0, 8'd0);
    wait_rsp("bypass00", 1'b0, 8'd0, 1'b0);
    chk("bypass_no_start", cm_starts - s0, 0);

    // Response backpressure.
    bus.rsp_ready = 1'b0;
    send(1'b0, 8'd100, 8'd75);
    bus.req1_valid = 1'b1; bus.req1_x = 8'd3; bus.req1_y = 8'd9;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) break;
    end
    for (int c = 0; c < 5; c++) begin
      chk("bp_gcd", bus.rsp_gcd, 25);
      chk("bp_req1_ready", bus.req1_ready, 0);
      chk("bp_busy", bus.busy, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idle", bus.busy, 0);
    @(posedge clk);
    #1 bus.req1_valid = 1'b0;
    wait_idle("bp");

    // Randomized traffic with random core latency and response backpressure.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (a0 || !bus.req0_valid) begin
        bus.req0_valid = ($urandom_range(0, 1) == 0);
        bus.req0_x = rnd_op();
        bus.req0_y = rnd_op();
      end
      if (a1 || !bus.req1_valid) begin
        bus.req1_valid = ($urandom_range(0, 1) == 0);
        bus.req1_x = rnd_op();
        bus.req1_y = rnd_op();
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    wait_idle("random");

`ifdef GCD_SCHED_TIMEOUT_EN
    // Core never finishes: abort and error response.
    cm_lat = 1000;
    ab0 = n_abort;
    send(1'b0, 8'd20, 8'd15);
    wait_rsp("timeout", 1'b0, 8'd0, 1'b1);
    chk("timeout_abort", n_abort - ab0, 1);
    do_reset();
    // Done on the timeout cycle wins.
    cm_lat = TO;
    ab0 = n_abort;
    send(1'b1, 8'd20, 8'd15);
    wait_rsp("coincident", 1'b1, 8'd5, 1'b0);
    chk("coincident_no_abort", n_abort - ab0, 0);
`else
    ab0 = n_abort;
    do_reset();
    chk("no_abort_ever", n_abort - ab0 + n_abort, 0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
